ptp_bmca_ann_scheduler: RTL and testbench

PTP_BMCA_ANN_SCHEDULER -- requirements
Module: ptp_bmca_ann_scheduler

---
 rtl/ptp_bmca_pkg.sv | 10 +
 rtl/ptp_rr_arbiter.sv | 34 +++
 rtl/ptp_bmca_ann_scheduler.sv | 143 ++++++++++++++
 tb/tb_ptp_bmca_ann_scheduler.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_bmca_pkg.sv
// Shared FSM encodings and defaults for the PTP BMCA announce scheduler.
package ptp_bmca_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GRANT     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  localparam int unsigned TMO_WIDTH_DEF = 32;

endpackage

// File: rtl/ptp_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at the index after `last`
// and wraps, returning a one-hot grant and the matching index.
module ptp_rr_arbiter #(
  parameter int unsigned PORT_NUM       = 8,
  parameter int unsigned PORT_NUM_WIDTH = $clog2(PORT_NUM)
) (
  input  logic [PORT_NUM-1:0]       req,
  input  logic [PORT_NUM_WIDTH-1:0] last,
  output logic [PORT_NUM-1:0]       grant,
  output logic [PORT_NUM_WIDTH-1:0] idx,
  output logic                      valid
);

  int unsigned               cand;
  logic [PORT_NUM_WIDTH-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= PORT_NUM; i++) begin
      cand     = (32'(last) + i) % PORT_NUM;
      cand_idx = cand[PORT_NUM_WIDTH-1:0];
      if (!valid && req[cand_idx]) begin
        valid           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ptp_bmca_ann_scheduler.sv
// Round-robin scheduler feeding parsed Announce vectors to a shared BMCA comparator.
// Define PTP_ANN_TMO_EN to include per-port announce receipt timeout counters.
module ptp_bmca_ann_scheduler
  import ptp_bmca_pkg::*;
#(
  parameter int unsigned PORT_NUM       = 8,
  parameter int unsigned PORT_NUM_WIDTH = $clog2(PORT_NUM),
  parameter int unsigned TMO_WIDTH      = TMO_WIDTH_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [PORT_NUM-1:0]       i_port_link,
  input  logic [PORT_NUM-1:0]       i_ann_req,
  input  logic [TMO_WIDTH-1:0]      i_ann_tmo_cycles,
  input  logic                      i_round_start,
  input  logic                      i_cmp_done,
  output logic [PORT_NUM_WIDTH-1:0] o_sel_port,
  output logic                      o_sel_valid,
  output logic                      o_busy,
  output logic [PORT_NUM-1:0]       o_pending,
  output logic [PORT_NUM-1:0]       o_port_timeout,
  output logic [PORT_NUM-1:0]       o_round_served,
  output logic                      o_round_done
);

  logic [1:0]                state;
  logic [PORT_NUM-1:0]       pending;
  logic [PORT_NUM-1:0]       served;
  logic [PORT_NUM-1:0]       sel_oh;
  logic [PORT_NUM-1:0]       grant_clr;
  logic [PORT_NUM-1:0]       served_set;
  logic [PORT_NUM-1:0]       tmo_hit;
  logic [PORT_NUM-1:0]       arb_req;
  logic [PORT_NUM-1:0]       arb_grant;
  logic [PORT_NUM_WIDTH-1:0] sel;
  logic [PORT_NUM_WIDTH-1:0] last;
  logic [PORT_NUM_WIDTH-1:0] arb_idx;
  logic                      arb_valid;
  logic                      armed;
  logic                      round_done;
  logic                      done_cond;

  assign arb_req = pending & i_port_link;

  ptp_rr_arbiter #(
    .PORT_NUM       (PORT_NUM),
    .PORT_NUM_WIDTH (PORT_NUM_WIDTH)
  ) u_arb (
    .req   (arb_req),
    .last  (last),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state  <= ST_IDLE;
      sel    <= '0;
      sel_oh <= '0;
      last   <= PORT_NUM_WIDTH'(PORT_NUM - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            sel    <= arb_idx;
            sel_oh <= arb_grant;
            last   <= arb_idx;
            state  <= ST_GRANT;
          end
        end
        ST_GRANT:     state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (i_cmp_done) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  // A request arriving in the GRANT cycle survives the grant clear.
  assign grant_clr  = (state == ST_GRANT) ? sel_oh : '0;
  // A port whose link dropped while being compared is not counted as served.
  assign served_set = tmo_hit |
                      (((state == ST_WAIT_DONE) && i_cmp_done) ? (sel_oh & i_port_link) : '0);
  assign done_cond  = armed && (state == ST_IDLE) && !i_round_start &&
                      (&(served | ~i_port_link));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pending    <= '0;
      served     <= '0;
      armed      <= 1'b0;
      round_done <= 1'b0;
    end else begin
      pending    <= i_port_link & (i_ann_req | (pending & ~grant_clr));
      served     <= (i_round_start ? '0 : served) | served_set;
      armed      <= i_round_start ? 1'b1 : (done_cond ? 1'b0 : armed);
      round_done <= done_cond;
    end
  end

`ifdef PTP_ANN_TMO_EN
  logic                 tmo_on;
  logic [TMO_WIDTH-1:0] tmo_last;

  assign tmo_on   = (i_ann_tmo_cycles != '0);
  assign tmo_last = i_ann_tmo_cycles - TMO_WIDTH'(1);

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_tmo
    logic [TMO_WIDTH-1:0] cnt;

    assign tmo_hit[p] = tmo_on && i_port_link[p] && !i_ann_req[p] &&
                        !i_round_start && (cnt == tmo_last);

    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        cnt <= '0;
      end else if (!tmo_on || !i_port_link[p] || i_ann_req[p] || i_round_start || tmo_hit[p]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + TMO_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) o_port_timeout <= '0;
    else        o_port_timeout <= tmo_hit;
  end
`else
  logic unused_tmo;
  assign unused_tmo     = ^i_ann_tmo_cycles;
  assign tmo_hit        = '0;
  assign o_port_timeout = '0;
`endif

  assign o_sel_port     = sel;
  assign o_sel_valid    = (state == ST_GRANT);
  assign o_busy         = (state != ST_IDLE);
  assign o_pending      = pending;
  assign o_round_served = served;
  assign o_round_done   = round_done;

endmodule

// File: tb/tb_ptp_bmca_ann_scheduler.sv
// Directed self-checking bench for ptp_bmca_ann_scheduler; timeout scenario
// expectations follow the PTP_ANN_TMO_EN build setting.
module tb_ptp_bmca_ann_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [7:0]  i_port_link = '0;
  logic [7:0]  i_ann_req = '0;
  logic [31:0] i_ann_tmo_cycles = '0;
  logic        i_round_start = 1'b0;
  logic        i_cmp_done = 1'b0;
  logic [2:0]  o_sel_port;
  logic        o_sel_valid;
  logic        o_busy;
  logic [7:0]  o_pending;
  logic [7:0]  o_port_timeout;
  logic [7:0]  o_round_served;
  logic        o_round_done;

  int n_checks = 0;
  int n_fail   = 0;

  ptp_bmca_ann_scheduler #(
    .PORT_NUM       (8),
    .PORT_NUM_WIDTH (3),
    .TMO_WIDTH      (32)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_port_link      (i_port_link),
    .i_ann_req        (i_ann_req),
    .i_ann_tmo_cycles (i_ann_tmo_cycles),
    .i_round_start    (i_round_start),
    .i_cmp_done       (i_cmp_done),
    .o_sel_port       (o_sel_port),
    .o_sel_valid      (o_sel_valid),
    .o_busy           (o_busy),
    .o_pending        (o_pending),
    .o_port_timeout   (o_port_timeout),
    .o_round_served   (o_round_served),
    .o_round_done     (o_round_done)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before 2ms");
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_valid(input int unsigned budget, output bit seen);
    seen = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      if (o_sel_valid === 1'b1) begin
        seen = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    i_port_link = '0;
    i_ann_req = '0;
    i_ann_tmo_cycles = '0;
    i_round_start = 1'b0;
    i_cmp_done = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({o_sel_valid, o_busy, o_round_done, o_sel_port} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b required 000000", {o_sel_valid, o_busy, o_round_done, o_sel_port});
    end
    n_checks++;
    if ({o_pending, o_round_served, o_port_timeout} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_vec: got %h required 000000", {o_pending, o_round_served, o_port_timeout});
    end
    i_port_link = 8'hFF;
    i_ann_req = 8'h01;
    tick();
    i_ann_req = '0;
    n_checks++;
    if (o_pending !== 8'h01 || o_sel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_n1: got pend=%h valid=%b required pend=01 valid=0", o_pending, o_sel_valid);
    end
    tick();
    n_checks++;
    if (o_sel_valid !== 1'b1 || o_sel_port !== 3'd0) begin
      n_fail++;
      $display("FAIL latency_n2: got valid=%b port=%0d required valid=1 port=0", o_sel_valid, o_sel_port);
    end
    i_ann_req = 8'h20;
    tick();
    i_ann_req = '0;
    n_checks++;
    if (o_sel_valid !== 1'b0 || o_busy !== 1'b1 || o_pending !== 8'h20) begin
      n_fail++;
      $display("FAIL grant_once: got valid=%b busy=%b pend=%h required 0 1 20", o_sel_valid, o_busy, o_pending);
    end
    i_rst = 1'b0;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_pending !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b pend=%h required busy=0 pend=00", o_busy, o_pending);
    end
    i_rst = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    bit seen;
    do_reset();
    i_port_link = 8'hFF;
    i_ann_req = 8'hFF;
    tick();
    i_ann_req = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      wait_valid(10, seen);
      n_checks++;
      if (!seen || o_sel_port !== 3'(k)) begin
        n_fail++;
        $display("FAIL fair_order: got seen=%b port=%0d required port=%0d", seen, o_sel_port, k);
      end
      tick();
      n_checks++;
      if (o_sel_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fair_strobe: got valid=%b required 0 after grant %0d", o_sel_valid, k);
      end
      tick();
      i_cmp_done = 1'b1;
      tick();
      i_cmp_done = 1'b0;
    end
    n_checks++;
    if (o_round_served !== 8'hFF || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fair_served: got served=%h busy=%b required FF 0", o_round_served, o_busy);
    end
  endtask

  task automatic test_collision();
    bit seen;
    logic [2:0] exp_seq [3];
    exp_seq[0] = 3'd3;
    exp_seq[1] = 3'd5;
    exp_seq[2] = 3'd3;
    do_reset();
    i_port_link = 8'hFF;
    i_ann_req = 8'h28;
    tick();
    i_ann_req = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      wait_valid(10, seen);
      n_checks++;
      if (!seen || o_sel_port !== exp_seq[k]) begin
        n_fail++;
        $display("FAIL collide_order: got seen=%b port=%0d required %0d", seen, o_sel_port, exp_seq[k]);
      end
      if (k == 0) i_ann_req = 8'h08;
      tick();
      i_ann_req = '0;
      if (k == 0) begin
        n_checks++;
        if (o_pending !== 8'h28) begin
          n_fail++;
          $display("FAIL collide_pend: got %h required 28", o_pending);
        end
      end
      tick();
      i_cmp_done = 1'b1;
      tick();
      i_cmp_done = 1'b0;
    end
    n_checks++;
    if (o_pending !== 8'h00) begin
      n_fail++;
      $display("FAIL collide_drain: got %h required 00", o_pending);
    end
  endtask

  task automatic test_all_links_down();
    do_reset();
    i_round_start = 1'b1;
    tick();
    i_round_start = 1'b0;
    n_checks++;
    if (o_round_done !== 1'b0) begin
      n_fail++;
      $display("FAIL down_done0: got %b required 0", o_round_done);
    end
    tick();
    n_checks++;
    if (o_round_done !== 1'b1) begin
      n_fail++;
      $display("FAIL down_done1: got %b required 1", o_round_done);
    end
    tick();
    n_checks++;
    if (o_round_done !== 1'b0) begin
      n_fail++;
      $display("FAIL down_done2: got %b required 0", o_round_done);
    end
    i_cmp_done = 1'b1;
    tick();
    i_cmp_done = 1'b0;
    n_checks++;
    if (o_busy !== 1'b0 || o_round_served !== 8'h00) begin
      n_fail++;
      $display("FAIL idle_cmp_done: got busy=%b served=%h required 0 00", o_busy, o_round_served);
    end
  endtask

  task automatic test_link_drop();
    bit seen;
    do_reset();
    i_port_link = 8'h07;
    i_round_start = 1'b1;
    i_ann_req = 8'h07;
    tick();
    i_round_start = 1'b0;
    i_ann_req = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      wait_valid(10, seen);
      n_checks++;
      if (!seen || o_sel_port !== 3'(k)) begin
        n_fail++;
        $display("FAIL drop_order: got seen=%b port=%0d required %0d", seen, o_sel_port, k);
      end
      tick();
      tick();
      i_cmp_done = 1'b1;
      tick();
      i_cmp_done = 1'b0;
    end
    wait_valid(10, seen);
    n_checks++;
    if (!seen || o_sel_port !== 3'd2) begin
      n_fail++;
      $display("FAIL drop_grant2: got seen=%b port=%0d required 2", seen, o_sel_port);
    end
    i_ann_req = 8'h04;
    tick();
    i_ann_req = '0;
    n_checks++;
    if (o_pending !== 8'h04) begin
      n_fail++;
      $display("FAIL drop_repend: got %h required 04", o_pending);
    end
    i_port_link = 8'h03;
    tick();
    n_checks++;
    if (o_pending !== 8'h00 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_clear: got pend=%h busy=%b required 00 1", o_pending, o_busy);
    end
    i_cmp_done = 1'b1;
    tick();
    i_cmp_done = 1'b0;
    n_checks++;
    if (o_round_served !== 8'h03 || o_round_done !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_served: got served=%h done=%b busy=%b required 03 0 0",
               o_round_served, o_round_done, o_busy);
    end
    tick();
    n_checks++;
    if (o_round_done !== 1'b1 || o_sel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_done: got done=%b valid=%b required 1 0", o_round_done, o_sel_valid);
    end
    tick();
    n_checks++;
    if (o_round_done !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_done_once: got %b required 0", o_round_done);
    end
  endtask

`ifdef PTP_ANN_TMO_EN
  task automatic test_timeout();
    do_reset();
    i_port_link = 8'h03;
    i_ann_tmo_cycles = 32'd100;
    i_round_start = 1'b1;
    tick();
    i_round_start = 1'b0;
    for (int unsigned c = 1; c <= 102; c++) begin
      i_ann_req = (c == 3) ? 8'h01 : 8'h00;
      i_cmp_done = (c == 10);
      tick();
      if (c == 4) begin
        n_checks++;
        if (o_sel_valid !== 1'b1 || o_sel_port !== 3'd0) begin
          n_fail++;
          $display("FAIL tmo_grant: got valid=%b port=%0d required 1 0", o_sel_valid, o_sel_port);
        end
      end
      if (c == 10) begin
        n_checks++;
        if (o_round_served !== 8'h01) begin
          n_fail++;
          $display("FAIL tmo_served0: got %h required 01", o_round_served);
        end
      end
      if (c == 99) begin
        n_checks++;
        if (o_port_timeout !== 8'h00 || o_round_done !== 1'b0) begin
          n_fail++;
          $display("FAIL tmo_early: got tmo=%h done=%b required 00 0", o_port_timeout, o_round_done);
        end
      end
      if (c == 100) begin
        n_checks++;
        if (o_port_timeout !== 8'h02 || o_round_served !== 8'h03 || o_round_done !== 1'b0) begin
          n_fail++;
          $display("FAIL tmo_pulse: got tmo=%h served=%h done=%b required 02 03 0",
                   o_port_timeout, o_round_served, o_round_done);
        end
      end
      if (c == 101) begin
        n_checks++;
        if (o_port_timeout !== 8'h00 || o_round_done !== 1'b1) begin
          n_fail++;
          $display("FAIL tmo_done: got tmo=%h done=%b required 00 1", o_port_timeout, o_round_done);
        end
      end
      if (c == 102) begin
        n_checks++;
        if (o_round_done !== 1'b0) begin
          n_fail++;
          $display("FAIL tmo_done_once: got %b required 0", o_round_done);
        end
      end
    end
    i_cmp_done = 1'b0;
    i_ann_tmo_cycles = '0;
  endtask
`else
  task automatic test_macro_off();
    bit tmo_seen;
    bit early_done;
    tmo_seen = 1'b0;
    early_done = 1'b0;
    do_reset();
    i_port_link = 8'h03;
    i_ann_tmo_cycles = 32'd100;
    i_round_start = 1'b1;
    tick();
    i_round_start = 1'b0;
    for (int unsigned c = 1; c <= 120; c++) begin
      i_ann_req = (c == 3) ? 8'h01 : ((c == 111) ? 8'h02 : 8'h00);
      i_cmp_done = (c == 10) || (c == 118);
      tick();
      if (o_port_timeout !== 8'h00) tmo_seen = 1'b1;
      if (o_round_done !== 1'b0 && c != 119) early_done = 1'b1;
      if (c == 10) begin
        n_checks++;
        if (o_round_served !== 8'h01) begin
          n_fail++;
          $display("FAIL off_served0: got %h required 01", o_round_served);
        end
      end
      if (c == 110) begin
        n_checks++;
        if (o_round_served !== 8'h01) begin
          n_fail++;
          $display("FAIL off_unserved1: got %h required 01", o_round_served);
        end
      end
      if (c == 112) begin
        n_checks++;
        if (o_sel_valid !== 1'b1 || o_sel_port !== 3'd1) begin
          n_fail++;
          $display("FAIL off_grant1: got valid=%b port=%0d required 1 1", o_sel_valid, o_sel_port);
        end
      end
      if (c == 119) begin
        n_checks++;
        if (o_round_done !== 1'b1 || o_round_served !== 8'h03) begin
          n_fail++;
          $display("FAIL off_done: got done=%b served=%h required 1 03", o_round_done, o_round_served);
        end
      end
    end
    n_checks++;
    if (tmo_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL off_no_timeout: got pulse=%b required 0", tmo_seen);
    end
    n_checks++;
    if (early_done !== 1'b0) begin
      n_fail++;
      $display("FAIL off_no_early_done: got early=%b required 0", early_done);
    end
    i_cmp_done = 1'b0;
    i_ann_tmo_cycles = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_fairness();
    test_collision();
    test_all_links_down();
    test_link_drop();
`ifdef PTP_ANN_TMO_EN
    test_timeout();
`else
    test_macro_off();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
